// File: rtl/agu_nrf_wr_sched_if.sv
// Write-port bundle between the AGU writers and the N register file scheduler.
// Carries no state and adds no latency; it only groups the A/B/M requests and the scheduler outputs.
// m_ready is the only backpressure signal; A and B are never stalled.
// Ports: flush; A/B/M requests (valid/addr/data); m_ready; port 1/2 write strobe, address and data; busy; collide.
interface agu_nrf_wr_sched_if;
    logic        flush;
    logic        a_valid;
    logic [1:0]  a_addr;
    logic [15:0] a_data;
    logic        b_valid;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_addr;
    logic [15:0] m_data;
    logic        write1;
    logic [1:0]  waddr1;
    logic [15:0] in1;
    logic        write2;
    logic [1:0]  waddr2;
    logic [15:0] in2;
    logic [3:0]  busy;
    logic        collide;

    // master: the writers / register file side
    modport master (
        output flush, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               m_valid, m_addr, m_data,
        input  m_ready, write1, waddr1, in1, write2, waddr2, in2, busy, collide
    );

    // slave: the scheduler
    modport slave (
        input  flush, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               m_valid, m_addr, m_data,
        output m_ready, write1, waddr1, in1, write2, waddr2, in2, busy, collide
    );
endinterface

// File: rtl/agu_nrf_wr_sched.sv
// Merges AGU units A/B and the queued move path M onto the two registered N-file write ports.
// Latency: A/B strobe one cycle after request; M strobe two or more cycles after acceptance.
// Backpressure: only M, via m_ready = FIFO not full; A and B are always accepted.
// Ports: Clk, Reset_n (async, active low), bus (slave modport: requests in, write ports/busy/collide out).
module agu_nrf_wr_sched #(
    parameter int DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    agu_nrf_wr_sched_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    // FIFO storage; fifo_vld marks an occupied entry that has not been superseded
    logic [1:0]       fifo_addr [DEPTH];
    logic [15:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_vld, vld_nxt, kill;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW-1:0]    head, wr_idx;
    logic             empty, full, head_live, take_head, pop, push;
    logic             coll, b_eff, ab_both;

    logic             p1_vld, p2_vld;
    logic [1:0]       p1_addr, p2_addr;
    logic [15:0]      p1_data, p2_data;

    logic             write1_q, write2_q, collide_q;
    logic [1:0]       waddr1_q, waddr2_q;
    logic [15:0]      in1_q, in2_q;
    logic [3:0]       busy_c;

    assign head   = rd_ptr[AW-1:0];
    assign wr_idx = wr_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == head);

    assign coll    = bus.a_valid && bus.b_valid && (bus.a_addr == bus.b_addr);
    assign b_eff   = bus.b_valid && !coll;
    assign ab_both = bus.a_valid && b_eff;

    // Queued moves are older than this cycle's AGU updates: any matching entry is superseded.
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] &&
                ((bus.a_valid && fifo_addr[i] == bus.a_addr) ||
                 (bus.b_valid && fifo_addr[i] == bus.b_addr)))
                kill[i] = 1'b1;
        end
    end

    // A flush discards the head too, so nothing drains in the flush cycle.
    assign head_live = !empty && !bus.flush && fifo_vld[head] && !kill[head];

    always_comb begin
        p1_vld    = 1'b0;
        p1_addr   = '0;
        p1_data   = '0;
        p2_vld    = 1'b0;
        p2_addr   = '0;
        p2_data   = '0;
        take_head = 1'b0;
        if (bus.a_valid) begin
            p1_vld  = 1'b1;
            p1_addr = bus.a_addr;
            p1_data = bus.a_data;
        end else if (bus.b_valid) begin
            p1_vld  = 1'b1;
            p1_addr = bus.b_addr;
            p1_data = bus.b_data;
        end else if (head_live) begin
            p1_vld    = 1'b1;
            p1_addr   = fifo_addr[head];
            p1_data   = fifo_data[head];
            take_head = 1'b1;
        end
        if (ab_both) begin
            p2_vld  = 1'b1;
            p2_addr = bus.b_addr;
            p2_data = bus.b_data;
        end else if (head_live && !take_head) begin
            p2_vld    = 1'b1;
            p2_addr   = fifo_addr[head];
            p2_data   = fifo_data[head];
            take_head = 1'b1;
        end
    end

    // Superseded or marked heads pop without a port; each pop uses the single per-cycle drain.
    assign pop  = !empty && !bus.flush && (take_head || !fifo_vld[head] || kill[head]);
    assign push = bus.m_valid && !full && !bus.flush;

    always_comb begin
        vld_nxt = fifo_vld & ~kill;
        if (pop)
            vld_nxt[head] = 1'b0;
        // push only happens when not full, so wr_idx never aliases a live entry
        if (push)
            vld_nxt[wr_idx] = 1'b1;
        if (bus.flush)
            vld_nxt = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_vld  <= '0;
            write1_q  <= 1'b0;
            waddr1_q  <= '0;
            in1_q     <= '0;
            write2_q  <= 1'b0;
            waddr2_q  <= '0;
            in2_q     <= '0;
            collide_q <= 1'b0;
        end else begin
            write1_q  <= p1_vld;
            waddr1_q  <= p1_addr;
            in1_q     <= p1_data;
            write2_q  <= p2_vld;
            waddr2_q  <= p2_addr;
            in2_q     <= p2_data;
            collide_q <= coll;
            fifo_vld  <= vld_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Payload needs no reset: fifo_vld gates every use.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= bus.m_addr;
            fifo_data[wr_idx] <= bus.m_data;
        end
    end

    always_comb begin
        busy_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i])
                busy_c[fifo_addr[i]] = 1'b1;
        end
        if (write1_q)
            busy_c[waddr1_q] = 1'b1;
        if (write2_q)
            busy_c[waddr2_q] = 1'b1;
    end

    assign bus.m_ready = !full;
    assign bus.write1  = write1_q;
    assign bus.waddr1  = waddr1_q;
    assign bus.in1     = in1_q;
    assign bus.write2  = write2_q;
    assign bus.waddr2  = waddr2_q;
    assign bus.in2     = in2_q;
    assign bus.busy    = busy_c;
    assign bus.collide = collide_q;
endmodule

// File: doc/agu_nrf_wr_sched.md
# agu_nrf_wr_sched

Write-port scheduler for the AGU N register file (4 × 16-bit, two write ports). It merges three writers onto the file's two registered write ports: AGU update unit A, AGU update unit B and the move/bus path M. A and B are never stalled. M writes are buffered in a small FIFO and drain into free write slots. The block also publishes a per-register pending-write mask so the AGU can stall reads of registers that have an outstanding write.

## Interface
Parameters:
- DEPTH, 2 — M FIFO entries; power of two, 2..8.

Ports:
- Clk  in  1  — single clock; all state updates on posedge.
- Reset_n  in  1  — asynchronous, active-low reset.
- flush  in  1  — synchronous; discards all M FIFO entries.
- a_valid  in  1  — unit A write request; always accepted.
- a_addr  in  2 (`rfbus)  — unit A register index.
- a_data  in  16 (`addrbus)  — unit A write data.
- b_valid  in  1  — unit B write request; always accepted.
- b_addr  in  2  — unit B register index.
- b_data  in  16  — unit B write data.
- m_valid  in  1  — move/bus write request.
- m_ready  out  1  — M FIFO not full; the transfer occurs when m_valid && m_ready.
- m_addr  in  2  — move register index.
- m_data  in  16  — move write data.
- write1  out  1  — registered write strobe to file port 1.
- waddr1  out  2  — registered write address, port 1.
- in1  out  16  — registered write data, port 1.
- write2  out  1  — registered write strobe to file port 2.
- waddr2  out  2  — registered write address, port 2.
- in2  out  16  — registered write data, port 2.
- busy  out  4  — bit r = 1 while a write to N[r] is held in the FIFO or in the output stage.
- collide  out  1  — one-cycle pulse: an A/B same-address collision dropped the B write.

## Operation
- Slot selection is evaluated each cycle from the inputs and the FIFO contents before that edge. Results are registered into the port-1/port-2 output stage.
- A/B same-address collision: if a_valid && b_valid && a_addr == b_addr, A wins. B is dropped and collide pulses on the next cycle.
- Port 1 source, by priority: A; else B; else the FIFO head.
- Port 2 source:
  - B when A is also valid and the collision rule did not drop B.
  - Otherwise the FIFO head, if port 1 did not take it.
- Drain limit: at most one FIFO entry drains per cycle. The head drains only if a port is free.
- Supersede rule: a FIFO entry present before this edge whose address matches a valid A or B address this cycle is killed (removed without writing). A and B are newer than queued moves.
  - A killed head counts as drained.
  - Entries killed elsewhere in the queue are marked invalid and skipped when they reach the head. They still occupy a slot until popped; popping a marked entry consumes the cycle's single drain.
- An M write accepted in the same cycle as a same-address A/B write is enqueued normally and writes afterwards. Moves are ordered after same-cycle AGU updates.
- Simultaneous enqueue and drain in the same cycle are both performed.
  - m_ready = !full, evaluated before the edge. No pass-through when full.
  - Empty FIFO + m_valid + free port: the M write still goes through the FIFO, so the register write occurs one cycle later.
- flush empties the FIFO on the next edge. An M request presented in the flush cycle is discarded. A/B writes in the flush cycle proceed normally.
- busy[r] is combinational OR over valid FIFO entries and the registered write1/write2 stage addresses.
- While Reset_n is low, m_valid, a_valid and b_valid are ignored.

## Timing
- Reset values:
  - write1 = write2 = 0; waddr1 = waddr2 = 0; in1 = in2 = 0.
  - collide = 0; busy = 0.
  - FIFO empty; m_ready = 1.
- Latency:
  - A/B request in cycle n: write strobe high in cycle n+1, so the register file updates at edge n+2.
  - M request accepted in cycle n: earliest strobe in cycle n+2.
- Port strobes are high for exactly one cycle per write. No write is ever issued twice.
- Throughput: 2 writes/cycle. M drains one entry per cycle when A and B leave a slot free.
- Asynchronous reset mid-operation clears the FIFO and output stage immediately. Pending M writes are lost by design.
- FIFO pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.

## Test plan
- Reset release: all outputs at reset values, m_ready = 1. Then A{addr 2, 0x1234} → cycle+1: write1 = 1, waddr1 = 2, in1 = 0x1234, write2 = 0, busy = 4'b0100.
- A{1, 0xAAAA} + B{1, 0x5555} same cycle → port 1 writes 0xAAAA to N1, write2 = 0, collide pulses once.
- A and B valid (addr 0, 3) for 3 cycles with 3 M writes offered → m_ready drops after 2 accepts. After A/B stop, queued moves drain one per cycle in order.
- M{2, 0x0F0F} queued while A/B are busy, then A{2, 0x7777} → move is killed, no further write to N2, busy[2] clears after the A write leaves the output stage.
- FIFO holding 2 entries + flush → no M strobes follow, busy clears, m_ready = 1 next cycle.
- Assert Reset_n low while the FIFO is full and writes are in flight → write1/write2 = 0 immediately. No queued writes appear after release.
